uart_tx_line_arbiter: RTL and testbench
=======================================

// Module: uart_tx_line_arbiter
// PURPOSE
//  Shares one UART transmit datapath (uart_tx core / console pin) among NUM_REQ byte-stream requesters.
//  Arbitration is round-robin at line granularity: a grant is held until the granted requester sends EOL_CHAR,
//  so log lines from different harts/agents never interleave on the wire or in the receiving UART model.
//  Sits between requester FIFOs and the single uart_tx; one output register stage, valid/ready both sides.
// PARAMETERS
//  NUM_REQ         4         number of requesters (>=2)
//  PAYLOAD_BITS    8         byte width, matches uart_tx PAYLOAD_BITS
//  EOL_CHAR        8'h0A     byte value that ends a line and releases the grant
//  TIMEOUT_CYCLES  65536     idle cycles while granted before forced release (timeout build only)
// PORTS
//  clk           in   1                      system clock
//  reset         in   1                      synchronous reset, active-high
//  req_valid     in   NUM_REQ                per-requester byte valid
//  req_data      in   NUM_REQ*PAYLOAD_BITS   per-requester byte; requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
//  req_ready     out  NUM_REQ                per-requester accept; one-hot or zero
//  tx_valid      out  1                      byte valid toward uart_tx
//  tx_data       out  PAYLOAD_BITS           byte toward uart_tx
//  tx_ready      in   1                      uart_tx accepts byte (not busy)
//  grant_active  out  1                      a requester currently owns the line
//  grant_id      out  $clog2(NUM_REQ)        index of owner (valid when grant_active)
//  timeout_pulse out  1                      1-cycle pulse on forced release
// BEHAVIOUR
//  Reset (sync, active-high): tx_valid=0, tx_data=0, grant_active=0, grant_id=0, timeout_pulse=0,
//   req_ready=0, last_grant=NUM_REQ-1 (requester 0 highest priority first), timeout counter=0.
//   Reset mid-line/mid-byte: pending tx byte discarded, grant dropped, no partial state survives.
//  FSM: IDLE -> GRANTED -> IDLE.
//   IDLE: if any req_valid, pick first set bit scanning last_grant+1, +2, ... (mod NUM_REQ);
//    next cycle grant_active=1, grant_id=winner. No req_valid -> stay IDLE.
//   GRANTED: req_ready[grant_id] = (!tx_valid || tx_ready), combinational; all other req_ready=0.
//    fire = req_valid[g] && req_ready[g]: tx_data<=req_data[g], tx_valid<=1 next cycle.
//    fire with byte==EOL_CHAR: last_grant<=g, next state IDLE (grant_active=0 next cycle).
//    requester dropping req_valid mid-line does NOT release the grant (line atomicity).
//  Output stage: tx_valid held, tx_data stable until tx_ready; tx_valid && tx_ready && no new fire -> tx_valid=0.
//   Back-to-back bytes at 1/cycle when tx_ready stays high.
//  Arbitration may occur while last byte of previous line still pending in output register; new owner's
//   req_ready stays low until slot frees. Bytes leave in acceptance order; nothing dropped or duplicated.
//  Latency: req_valid rises in IDLE (tx free) -> grant_active +1 cycle -> fire same cycle -> tx_valid +2 cycles.
//  EOL fire: one dead cycle in IDLE before next grant (re-arbitration bubble).
//  Single-byte line (first byte == EOL_CHAR): grant for exactly one fire, then release.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: counter increments each GRANTED cycle without fire, clears on fire or
//   grant change; at TIMEOUT_CYCLES-1 -> release to IDLE, last_grant<=g, timeout_pulse=1 for one cycle.
//   Same-cycle fire and timeout: fire wins, counter clears, no pulse; EOL fire releases normally.
//  UART_ARB_TIMEOUT_EN undefined: no counter; grant held until EOL_CHAR; timeout_pulse tied 0.
// TESTING
//  1. Req0 sends "AB\n", tx_ready=1 -> tx_data 8'h41,8'h42,8'h0A consecutive; first tx_valid 2 cycles after req_valid.
//  2. Req1 and req2 both send lines at once -> req1's full line, then req2's full line; no interleaving; next tie -> req2 after req1 skipped order per RR.
//  3. tx_ready low 10 cycles while tx_valid=1 with 8'h41 -> tx_data stays 8'h41, req_ready[g]=0, byte emitted once.
//  4. Req3 sends "X" then drops req_valid, req0 waiting -> grant stays 3; timeout build: pulse after 65536 idle cycles, grant moves to 0.
//  5. Assert reset mid-line with tx_valid=1 -> next cycle tx_valid=0, grant_active=0; after release req0 wins first.
//  6. Single-byte line 8'h0A from req2 -> one fire, grant_active falls next cycle, last_grant=2.

Source files
------------

// File: rtl/uart_tx_line_arbiter.sv
// uart_tx_line_arbiter
//   Round-robin arbiter sharing one uart_tx byte path among NUM_REQ requesters.
//   A grant is held for a whole line: it is released only when the owner sends
//   EOL_CHAR, so lines from different sources never interleave on the wire.
//   One output register stage; valid/ready handshake on both sides.
//
//   Optional build macro: UART_ARB_TIMEOUT_EN
//     defined   -> a granted owner that stalls for TIMEOUT_CYCLES idle cycles is
//                  force-released and timeout_pulse fires for one cycle.
//     undefined -> grant held until EOL_CHAR; timeout_pulse tied low.
//
//   state   | meaning
//   IDLE    | no owner; arbitrate among req_valid starting after last_grant
//   GRANTED | grant_id owns the line until EOL_CHAR (or timeout)
module uart_tx_line_arbiter #(
   parameter int                      NUM_REQ        = 4,
   parameter int                      PAYLOAD_BITS   = 8,
   parameter logic [PAYLOAD_BITS-1:0] EOL_CHAR       = PAYLOAD_BITS'(8'h0A),
   parameter int                      TIMEOUT_CYCLES = 65536
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            tx_valid,
   output logic [PAYLOAD_BITS-1:0]         tx_data,
   input  logic                            tx_ready,
   output logic                            grant_active,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic                            timeout_pulse
);

   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [IDW-1:0]          grant_id_q, grant_id_d;
   logic [IDW-1:0]          last_grant_q, last_grant_d;
   logic                    tx_valid_q;
   logic [PAYLOAD_BITS-1:0] tx_data_q;

   logic [PAYLOAD_BITS-1:0] req_byte [NUM_REQ];
   logic [PAYLOAD_BITS-1:0] cur_byte;
   logic                    arb_found;
   logic [IDW-1:0]          arb_winner;
   logic [IDW-1:0]          scan_idx;
   logic                    slot_free;
   logic                    fire;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tout_cnt_q;
   logic          timeout_hit;
   logic          timeout_pulse_q;
`endif

   // Unpack the flat requester data bus into per-requester bytes.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_byte[i] = req_data[i*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
   end

   assign cur_byte  = req_byte[grant_id_q];
   // The output slot can take a new byte when empty or being drained this cycle.
   assign slot_free = !tx_valid_q || tx_ready;

   // Round-robin pick: first valid requester after last_grant, wrapping.
   always_comb begin
      arb_found  = 1'b0;
      arb_winner = '0;
      scan_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan_idx = IDW'((int'(last_grant_q) + k) % NUM_REQ);
         if (!arb_found && req_valid[scan_idx]) begin
            arb_found  = 1'b1;
            arb_winner = scan_idx;
         end
      end
   end

   // Next-state, grant bookkeeping and the owner's ready/fire.
   always_comb begin
      state_d      = state_q;
      grant_id_d   = grant_id_q;
      last_grant_d = last_grant_q;
      req_ready    = '0;
      fire         = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_hit  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (arb_found) begin
               state_d    = GRANTED;
               grant_id_d = arb_winner;
            end
         end
         GRANTED: begin
            req_ready[grant_id_q] = slot_free;
            fire = req_valid[grant_id_q] && slot_free;
            if (fire && (cur_byte == EOL_CHAR)) begin
               state_d      = IDLE;
               last_grant_d = grant_id_q;
            end
`ifdef UART_ARB_TIMEOUT_EN
            // A fire in the same cycle always wins over the timeout.
            else if (!fire && (tout_cnt_q == CW'(TIMEOUT_CYCLES - 1))) begin
               state_d      = IDLE;
               last_grant_d = grant_id_q;
               timeout_hit  = 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State, grant registers and the single output byte stage.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         grant_id_q   <= '0;
         last_grant_q <= IDW'(NUM_REQ - 1);
         tx_valid_q   <= 1'b0;
         tx_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_id_q   <= grant_id_d;
         last_grant_q <= last_grant_d;
         if (fire) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= cur_byte;
         end else if (tx_ready) begin
            tx_valid_q <= 1'b0;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   // Idle-while-granted counter; cleared on any fire or change of ownership.
   always_ff @(posedge clk) begin
      if (reset) begin
         tout_cnt_q      <= '0;
         timeout_pulse_q <= 1'b0;
      end else begin
         timeout_pulse_q <= timeout_hit;
         if ((state_q != GRANTED) || fire || (state_d != GRANTED)) begin
            tout_cnt_q <= '0;
         end else begin
            tout_cnt_q <= tout_cnt_q + 1'b1;
         end
      end
   end

   assign timeout_pulse = timeout_pulse_q;
`else
   assign timeout_pulse = 1'b0;
`endif

   assign tx_valid     = tx_valid_q;
   assign tx_data      = tx_data_q;
   assign grant_active = (state_q == GRANTED);
   assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_uart_tx_line_arbiter.sv
// Directed bench for uart_tx_line_arbiter (default build, timeout disabled).
// Each requester is modelled as a byte queue; bytes leave the queue when the
// DUT accepts them and every byte accepted by uart_tx is captured in order.
module tb_uart_tx_line_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        grant_active;
   logic [1:0]  grant_id;
   logic        timeout_pulse;

   int checks = 0;
   int errors = 0;

   logic [7:0] rq [4][$];
   logic [7:0] cap [$];

   uart_tx_line_arbiter #(
      .NUM_REQ(4), .PAYLOAD_BITS(8), .EOL_CHAR(8'h0A), .TIMEOUT_CYCLES(65536)
   ) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .grant_active(grant_active), .grant_id(grant_id),
      .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         req_valid[i] = (rq[i].size() > 0);
         req_data[i*8 +: 8] = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
      end
   endtask

   // One clock: sample handshakes mid-cycle, advance, then update requesters.
   task automatic tick();
      logic [3:0] fire_v;
      @(negedge clk);
      fire_v = req_valid & req_ready;
      if (tx_valid && tx_ready) cap.push_back(tx_data);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (fire_v[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      drive();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tx_ready = 1'b1;
      drive();
      tick();
      tick();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %0b exp 0", tx_valid); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
      checks++; if (grant_active !== 1'b0) begin errors++; $display("FAIL reset_grant_active got %0b exp 0", grant_active); end
      checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id got %0d exp 0", grant_id); end
      checks++; if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_timeout_pulse got %0b exp 0", timeout_pulse); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", req_ready); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_line();
      logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h0A};
      cap.delete();
      rq[0] = '{8'h41, 8'h42, 8'h0A};
      drive();
      tick();
      checks++; if (grant_active !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL line_grant got act=%0b id=%0d exp act=1 id=0", grant_active, grant_id); end
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL line_latency1 tx_valid got %0b exp 0", tx_valid); end
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL line_req_ready got %b exp 0001", req_ready); end
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL line_first_byte got v=%0b d=%h exp v=1 d=41", tx_valid, tx_data); end
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin errors++; $display("FAIL line_second_byte got v=%0b d=%h exp v=1 d=42", tx_valid, tx_data); end
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h0A || grant_active !== 1'b0) begin errors++; $display("FAIL line_eol got v=%0b d=%h act=%0b exp v=1 d=0a act=0", tx_valid, tx_data, grant_active); end
      tick();
      checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL line_drain tx_valid got %0b exp 0", tx_valid); end
      checks++; if (cap.size() != 3) begin errors++; $display("FAIL line_count got %0d exp 3", cap.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL line_byte%0d got %h exp %h", i, cap[i], exp[i]); end
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] exp1 [5] = '{8'h31, 8'h32, 8'h0A, 8'h61, 8'h0A};
      logic [7:0] exp2 [4] = '{8'h34, 8'h0A, 8'h33, 8'h0A};
      cap.delete();
      rq[1] = '{8'h31, 8'h32, 8'h0A};
      rq[2] = '{8'h61, 8'h0A};
      drive();
      tick();
      checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL rr_first_winner got %0d exp 1", grant_id); end
      for (int c = 0; c < 12; c++) tick();
      checks++; if (cap.size() != 5) begin errors++; $display("FAIL rr_count got %0d exp 5", cap.size()); end
      else for (int i = 0; i < 5; i++) begin
         checks++; if (cap[i] !== exp1[i]) begin errors++; $display("FAIL rr_byte%0d got %h exp %h", i, cap[i], exp1[i]); end
      end
      cap.delete();
      rq[1] = '{8'h33, 8'h0A};
      rq[3] = '{8'h34, 8'h0A};
      drive();
      tick();
      checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL rr_second_winner got %0d exp 3", grant_id); end
      for (int c = 0; c < 10; c++) tick();
      checks++; if (cap.size() != 4) begin errors++; $display("FAIL rr2_count got %0d exp 4", cap.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (cap[i] !== exp2[i]) begin errors++; $display("FAIL rr2_byte%0d got %h exp %h", i, cap[i], exp2[i]); end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h0A};
      cap.delete();
      tx_ready = 1'b0;
      rq[0] = '{8'h41, 8'h42, 8'h0A};
      drive();
      tick();
      tick();
      for (int c = 0; c < 10; c++) begin
         checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL bp_hold cyc%0d got v=%0b d=%h rdy=%b exp v=1 d=41 rdy=0000", c, tx_valid, tx_data, req_ready);
         end
         tick();
      end
      tx_ready = 1'b1;
      for (int c = 0; c < 6; c++) tick();
      checks++; if (cap.size() != 3) begin errors++; $display("FAIL bp_count got %0d exp 3", cap.size()); end
      else for (int i = 0; i < 3; i++) begin
         checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d got %h exp %h", i, cap[i], exp[i]); end
      end
   endtask

   task automatic test_line_atomicity();
      logic [7:0] exp [4] = '{8'h58, 8'h0A, 8'h41, 8'h0A};
      cap.delete();
      rq[3] = '{8'h58};
      drive();
      tick();
      rq[0] = '{8'h41, 8'h0A};
      drive();
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++; if (grant_active !== 1'b1 || grant_id !== 2'd3 || req_ready[0] !== 1'b0 || timeout_pulse !== 1'b0) begin
            errors++; $display("FAIL atom_hold cyc%0d got act=%0b id=%0d rdy=%b to=%0b exp act=1 id=3 rdy0=0 to=0", c, grant_active, grant_id, req_ready, timeout_pulse);
         end
      end
      checks++; if (cap.size() != 1 || cap[0] !== 8'h58) begin errors++; $display("FAIL atom_partial got n=%0d exp n=1 d=58", cap.size()); end
      rq[3] = '{8'h0A};
      drive();
      for (int c = 0; c < 12; c++) tick();
      checks++; if (cap.size() != 4) begin errors++; $display("FAIL atom_count got %0d exp 4", cap.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL atom_byte%0d got %h exp %h", i, cap[i], exp[i]); end
      end
   endtask

   task automatic test_reset_midline();
      logic [7:0] exp [4] = '{8'h41, 8'h0A, 8'h58, 8'h0A};
      tx_ready = 1'b0;
      rq[1] = '{8'h31, 8'h32, 8'h0A};
      drive();
      tick();
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h31) begin errors++; $display("FAIL rst_pre got v=%0b d=%h exp v=1 d=31", tx_valid, tx_data); end
      reset = 1'b1;
      tick();
      checks++; if (tx_valid !== 1'b0 || grant_active !== 1'b0 || tx_data !== 8'h00) begin
         errors++; $display("FAIL rst_mid got v=%0b act=%0b d=%h exp v=0 act=0 d=00", tx_valid, grant_active, tx_data);
      end
      for (int i = 0; i < 4; i++) rq[i].delete();
      reset = 1'b0;
      tx_ready = 1'b1;
      drive();
      tick();
      cap.delete();
      rq[0] = '{8'h41, 8'h0A};
      rq[3] = '{8'h58, 8'h0A};
      drive();
      tick();
      checks++; if (grant_id !== 2'd0 || grant_active !== 1'b1) begin errors++; $display("FAIL rst_first_winner got id=%0d act=%0b exp id=0 act=1", grant_id, grant_active); end
      for (int c = 0; c < 12; c++) tick();
      checks++; if (cap.size() != 4) begin errors++; $display("FAIL rst_count got %0d exp 4", cap.size()); end
      else for (int i = 0; i < 4; i++) begin
         checks++; if (cap[i] !== exp[i]) begin errors++; $display("FAIL rst_byte%0d got %h exp %h", i, cap[i], exp[i]); end
      end
   endtask

   task automatic test_single_byte_line();
      cap.delete();
      rq[2] = '{8'h0A};
      drive();
      tick();
      checks++; if (grant_id !== 2'd2 || req_ready !== 4'b0100) begin errors++; $display("FAIL sb_grant got id=%0d rdy=%b exp id=2 rdy=0100", grant_id, req_ready); end
      tick();
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h0A || grant_active !== 1'b0 || req_ready !== 4'b0000) begin
         errors++; $display("FAIL sb_fire got v=%0b d=%h act=%0b rdy=%b exp v=1 d=0a act=0 rdy=0000", tx_valid, tx_data, grant_active, req_ready);
      end
      tick();
      checks++; if (tx_valid !== 1'b0 || cap.size() != 1) begin errors++; $display("FAIL sb_once got v=%0b n=%0d exp v=0 n=1", tx_valid, cap.size()); end
      rq[0] = '{8'h41, 8'h0A};
      rq[3] = '{8'h58, 8'h0A};
      drive();
      tick();
      checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL sb_last_grant next winner got %0d exp 3", grant_id); end
      for (int c = 0; c < 12; c++) tick();
   endtask

   initial begin
      reset = 1'b1;
      tx_ready = 1'b1;
      req_valid = '0;
      req_data = '0;
      test_reset();
      test_single_line();
      test_round_robin();
      test_backpressure();
      test_line_atomicity();
      test_reset_midline();
      test_single_byte_line();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
